// File: rtl/fir_tap_scheduler_if.sv
// fir_tap_scheduler_if
// Handshake/control bundle between the FIR tap scheduler and its neighbours
// (input FIFO, coefficient port, multiplier + accumulator datapath).
//   master : the scheduler (drives addresses/enables, reads FIFO/coef/ready)
//   slave  : the FIFO/datapath side
interface fir_tap_scheduler_if #(
  parameter int ADDR_W = 3
);
  logic              PushCoef;
  logic              fifo_empty;
  logic              out_ready;
  logic              fifoPullOut;
  logic              sample_wr_en;
  logic              sample_zero;
  logic [ADDR_W-1:0] sample_wr_addr;
  logic [ADDR_W-1:0] sample_rd_addr;
  logic              coef_wr_en;
  logic [ADDR_W-1:0] coef_wr_addr;
  logic [ADDR_W-1:0] coef_rd_addr;
  logic [1:0]        multiplier_mux_sel;
  logic              acc_clear;
  logic              partialProductAccumulate_valid;
  logic              finalAccumulateRounding_en;
  logic              busy;
  logic              coef_loaded;
  logic              coef_drop;

  modport master (
    input  PushCoef, fifo_empty, out_ready,
    output fifoPullOut, sample_wr_en, sample_zero, sample_wr_addr, sample_rd_addr,
           coef_wr_en, coef_wr_addr, coef_rd_addr, multiplier_mux_sel, acc_clear,
           partialProductAccumulate_valid, finalAccumulateRounding_en, busy,
           coef_loaded, coef_drop
  );

  modport slave (
    output PushCoef, fifo_empty, out_ready,
    input  fifoPullOut, sample_wr_en, sample_zero, sample_wr_addr, sample_rd_addr,
           coef_wr_en, coef_wr_addr, coef_rd_addr, multiplier_mux_sel, acc_clear,
           partialProductAccumulate_valid, finalAccumulateRounding_en, busy,
           coef_loaded, coef_drop
  );
endinterface

// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler
// Time-multiplexes one shared multiplier over all FIR taps per input sample.
// After reset it zero-fills the delay line, accepts coefficients while idle,
// pulls a sample from the FIFO, walks NTAPS x MUL_PASSES partial products,
// then holds the rounding enable until downstream accepts the result.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; all outputs forced to 0 while high
//   bus   : fir_tap_scheduler_if.master (FIFO/coef inputs, datapath controls)
module fir_tap_scheduler #(
  parameter int NTAPS      = 8,
  parameter int ADDR_W     = 3,
  parameter int MUL_PASSES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fir_tap_scheduler_if.master   bus
);
  typedef enum logic [2:0] {INIT, IDLE, PULL, MUL, ROUND} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NTAPS - 1);
  localparam logic [1:0]        LAST_PASS = 2'(MUL_PASSES - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] head, k, init_cnt, cptr;
  logic [1:0]        p;
  logic              coef_loaded;

  // Coefficients may only be written while no sample is in flight.
  logic coef_open, coef_acc, in_flight, take_sample;
  assign coef_open   = (state == INIT) || (state == IDLE);
  assign in_flight   = (state == PULL) || (state == MUL) || (state == ROUND);
  assign coef_acc    = bus.PushCoef && coef_open;
  // Uses the registered flag, so the write that completes the set cannot
  // also trigger a pull in the same cycle.
  assign take_sample = coef_loaded && !bus.fifo_empty;

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (init_cnt == LAST_TAP) state_nx = IDLE;
      IDLE:    if (take_sample) state_nx = PULL;
      PULL:    state_nx = MUL;
      MUL:     if (k == LAST_TAP && p == LAST_PASS) state_nx = ROUND;
      ROUND:   if (bus.out_ready) state_nx = take_sample ? PULL : IDLE;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      head        <= '0;
      k           <= '0;
      p           <= '0;
      init_cnt    <= '0;
      cptr        <= '0;
      coef_loaded <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        INIT: init_cnt <= init_cnt + 1'b1;
        PULL: begin
          k <= '0;
          p <= '0;
        end
        MUL: begin
          if (p == LAST_PASS) begin
            p <= '0;
            k <= k + 1'b1;
          end else begin
            p <= p + 1'b1;
          end
        end
        ROUND: if (bus.out_ready) head <= head + 1'b1;  // NTAPS is a power of two
        default: ;
      endcase
      if (coef_acc) begin
        cptr <= cptr + 1'b1;
        if (cptr == LAST_TAP) coef_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.fifoPullOut                    = 1'b0;
    bus.sample_wr_en                   = 1'b0;
    bus.sample_zero                    = 1'b0;
    bus.sample_wr_addr                 = '0;
    bus.sample_rd_addr                 = '0;
    bus.coef_wr_en                     = 1'b0;
    bus.coef_wr_addr                   = '0;
    bus.coef_rd_addr                   = '0;
    bus.multiplier_mux_sel             = '0;
    bus.acc_clear                      = 1'b0;
    bus.partialProductAccumulate_valid = 1'b0;
    bus.finalAccumulateRounding_en     = 1'b0;
    bus.busy                           = 1'b0;
    bus.coef_loaded                    = 1'b0;
    bus.coef_drop                      = 1'b0;
    if (!reset) begin
      bus.busy         = in_flight;
      bus.coef_loaded  = coef_loaded;
      bus.coef_wr_addr = cptr;
      bus.coef_wr_en   = coef_acc;
      bus.coef_drop    = bus.PushCoef && in_flight;
      case (state)
        INIT: begin
          bus.sample_wr_en   = 1'b1;
          bus.sample_zero    = 1'b1;
          bus.sample_wr_addr = init_cnt;
        end
        PULL: begin
          bus.fifoPullOut    = 1'b1;
          bus.sample_wr_en   = 1'b1;
          bus.sample_wr_addr = head;
          bus.acc_clear      = 1'b1;
        end
        MUL: begin
          bus.partialProductAccumulate_valid = 1'b1;
          bus.multiplier_mux_sel             = p;
          bus.coef_rd_addr                   = k;
          bus.sample_rd_addr                 = head - k;  // wraps mod NTAPS
        end
        ROUND: bus.finalAccumulateRounding_en = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_scheduler.sv
module tb_fir_tap_scheduler;
  localparam int NT = 8;
  localparam int MP = 4;

  logic clk, reset;
  fir_tap_scheduler_if #(.ADDR_W(3)) bus();

  fir_tap_scheduler #(.NTAPS(NT), .ADDR_W(3), .MUL_PASSES(MP)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: sample-level view. A sample occupies one PULL cycle,
  // NT*MP multiply cycles indexed by m_cyc, then a round phase.
  typedef enum int {M_INIT, M_IDLE, M_PULL, M_MUL, M_ROUND} mmode_t;
  mmode_t m_mode;
  int m_init, m_head, m_cyc, m_nco, m_pulls, dut_pulls;
  bit m_loaded;

  function automatic logic [23:0] dut_vec();
    return {bus.fifoPullOut, bus.sample_wr_en, bus.sample_zero, bus.sample_wr_addr,
            bus.sample_rd_addr, bus.coef_wr_en, bus.coef_wr_addr, bus.coef_rd_addr,
            bus.multiplier_mux_sel, bus.acc_clear, bus.partialProductAccumulate_valid,
            bus.finalAccumulateRounding_en, bus.busy, bus.coef_loaded, bus.coef_drop};
  endfunction

  function automatic logic [23:0] model_vec(input bit rst, input bit push);
    bit fp, we, z, cwe, clr, acc, rnd, bsy, ld, drp;
    int wa, ra, cwa, cra, mux;
    fp = 0; we = 0; z = 0; cwe = 0; clr = 0; acc = 0; rnd = 0; bsy = 0; ld = 0; drp = 0;
    wa = 0; ra = 0; cwa = 0; cra = 0; mux = 0;
    if (!rst) begin
      bsy = (m_mode == M_PULL) || (m_mode == M_MUL) || (m_mode == M_ROUND);
      ld  = m_loaded;
      cwa = m_nco % NT;
      cwe = push && !bsy;
      drp = push && bsy;
      case (m_mode)
        M_INIT:  begin we = 1; z = 1; wa = m_init; end
        M_PULL:  begin fp = 1; we = 1; wa = m_head; clr = 1; end
        M_MUL:   begin
          acc = 1;
          mux = m_cyc % MP;
          cra = m_cyc / MP;
          ra  = (m_head - m_cyc / MP + NT) % NT;
        end
        M_ROUND: rnd = 1;
        default: ;
      endcase
    end
    return {fp, we, z, 3'(wa), 3'(ra), cwe, 3'(cwa), 3'(cra), 2'(mux), clr, acc, rnd, bsy, ld, drp};
  endfunction

  task automatic model_update(input bit rst, input bit push, input bit fe, input bit ordy);
    bit accept;
    if (rst) begin
      m_mode = M_INIT; m_init = 0; m_head = 0; m_cyc = 0; m_nco = 0; m_loaded = 0;
      return;
    end
    accept = push && (m_mode == M_INIT || m_mode == M_IDLE);
    case (m_mode)
      M_INIT: begin
        if (m_init == NT - 1) m_mode = M_IDLE;
        m_init = (m_init + 1) % NT;
      end
      M_IDLE: if (m_loaded && !fe) m_mode = M_PULL;
      M_PULL: begin m_pulls++; m_cyc = 0; m_mode = M_MUL; end
      M_MUL: begin
        m_cyc++;
        if (m_cyc == NT * MP) m_mode = M_ROUND;
      end
      M_ROUND: if (ordy) begin
        m_head = (m_head + 1) % NT;
        m_mode = (m_loaded && !fe) ? M_PULL : M_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (m_nco % NT == NT - 1) m_loaded = 1;
      m_nco++;
    end
  endtask

  task automatic step(input bit rst, input bit push, input bit fe, input bit ordy);
    @(negedge clk);
    reset = rst; bus.PushCoef = push; bus.fifo_empty = fe; bus.out_ready = ordy;
    #1;
    chk($sformatf("outs@%0d", cyc_n), dut_vec(), model_vec(rst, push));
    if (bus.fifoPullOut === 1'b1) dut_pulls++;
    model_update(rst, push, fe, ordy);
    cyc_n++;
  endtask

  task automatic run_rand(input int n, input int push_pct, input int empty_pct, input int rdy_pct);
    for (int i = 0; i < n; i++)
      step(1'b0, $urandom_range(0, 99) < push_pct, $urandom_range(0, 99) < empty_pct,
           $urandom_range(0, 99) < rdy_pct);
  endtask

  initial begin
    bit reached;
    reset = 1'b1; bus.PushCoef = 1'b0; bus.fifo_empty = 1'b0; bus.out_ready = 1'b1;
    m_mode = M_INIT; m_init = 0; m_head = 0; m_cyc = 0; m_nco = 0; m_loaded = 0;
    m_pulls = 0; dut_pulls = 0;

    // Reset held, then zero-fill with a non-empty FIFO and no coefficients.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    // Full coefficient set while the FIFO already has data.
    for (int i = 0; i < NT; i++) step(0, 1, 0, 1);
    // One clean sample, then a backpressured back-to-back pair.
    for (int i = 0; i < NT * MP + 3; i++) step(0, 0, (m_mode == M_IDLE) ? 0 : 1, 1);
    for (int i = 0; i < 60; i++) step(0, 0, 0, (m_mode == M_ROUND) ? (i > 50) : 1);
    // Random traffic with occasional coefficient pushes (drops and reloads).
    run_rand(600, 5, 30, 70);

    // Reset in the middle of a multiply sequence.
    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if (m_mode == M_MUL && m_cyc == 10) reached = 1;
      else step(0, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20, 1);
    end
    chk("reach_mul10", 32'(reached), 32'd1);
    step(1, 0, 0, 1);
    run_rand(40, 0, 10, 80);
    for (int i = 0; i < NT; i++) step(0, 1, $urandom_range(0, 1), 1);
    run_rand(400, 4, 30, 60);

    chk("pull_count", 32'(dut_pulls), 32'(m_pulls));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
